// File: rtl/hbridge_dir_ctrl.sv
// rtl/hbridge_dir_ctrl.sv - H-bridge direction and dead-time controller for the MG33 motor
module hbridge_dir_ctrl #(
  parameter int DEAD_CYCLES       = 8,
  parameter int DIR_STABLE_CYCLES = 4
) (
  input  logic Clk_i,
  input  logic Reset_i,
  input  logic Pwm_i,
  input  logic Dir_i,
  input  logic En_i,
  output logic In1_o,
  output logic In2_o,
  output logic Dir_o,
  output logic Busy_o
);

  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_DEAD = 2'd1,
    ST_FWD  = 2'd2,
    ST_REV  = 2'd3
  } state_t;

  localparam logic [7:0] DEAD_LOAD   = 8'(DEAD_CYCLES);
  // The filter accepts on the DIR_STABLE_CYCLES-th consecutive differing sample,
  // so the compare is against the count already accumulated before this clock.
  localparam logic [7:0] STABLE_LAST = 8'(DIR_STABLE_CYCLES - 1);

  logic       sync_q;
  logic       dir_s;
  logic       dir_req;
  logic [7:0] filt_cnt;

  state_t     state;
  state_t     state_nxt;
  logic [7:0] dead_cnt;
  logic [7:0] dead_nxt;
  logic       dir_nxt;
  logic       in1_nxt;
  logic       in2_nxt;
  logic       busy_nxt;

  // Two-flop synchronizer for the asynchronous direction switch
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      sync_q <= 1'b0;
      dir_s  <= 1'b0;
    end else begin
      sync_q <= Dir_i;
      dir_s  <= sync_q;
    end
  end

  // Direction filter: accept dir_s only after it differs from dir_req long enough
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      dir_req  <= 1'b0;
      filt_cnt <= 8'd0;
    end else if (dir_s == dir_req) begin
      filt_cnt <= 8'd0;
    end else if (filt_cnt >= STABLE_LAST) begin
      dir_req  <= dir_s;
      filt_cnt <= 8'd0;
    end else begin
      filt_cnt <= filt_cnt + 8'd1;
    end
  end

  // Next-state logic; outputs are decoded from the next state so they move with it
  always_comb begin
    state_nxt = state;
    dead_nxt  = dead_cnt;
    dir_nxt   = Dir_o;
    case (state)
      ST_OFF: begin
        if (En_i) begin
          state_nxt = ST_DEAD;
          dead_nxt  = DEAD_LOAD;
        end
      end
      ST_DEAD: begin
        if (!En_i) begin
          state_nxt = ST_OFF;
          dead_nxt  = 8'd0;
        end else if (dead_cnt <= 8'd1) begin
          dir_nxt   = dir_req;
          state_nxt = dir_req ? ST_REV : ST_FWD;
          dead_nxt  = 8'd0;
        end else begin
          dead_nxt  = dead_cnt - 8'd1;
        end
      end
      ST_FWD, ST_REV: begin
        if (!En_i) begin
          state_nxt = ST_OFF;
        end else if (dir_req != Dir_o) begin
          state_nxt = ST_DEAD;
          dead_nxt  = DEAD_LOAD;
        end
      end
      default: begin
        state_nxt = ST_OFF;
        dead_nxt  = 8'd0;
      end
    endcase
    // Only one drive state can be next, so both legs can never be high together
    in1_nxt  = (state_nxt == ST_FWD) & Pwm_i;
    in2_nxt  = (state_nxt == ST_REV) & Pwm_i;
    busy_nxt = (state_nxt == ST_DEAD);
  end

  // State, dead-time counter and applied direction registers
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      state    <= ST_OFF;
      dead_cnt <= 8'd0;
      Dir_o    <= 1'b0;
    end else begin
      state    <= state_nxt;
      dead_cnt <= dead_nxt;
      Dir_o    <= dir_nxt;
    end
  end

  // Registered bridge outputs, cleared asynchronously by reset
  always_ff @(posedge Clk_i or negedge Reset_i) begin
    if (!Reset_i) begin
      In1_o  <= 1'b0;
      In2_o  <= 1'b0;
      Busy_o <= 1'b0;
    end else begin
      In1_o  <= in1_nxt;
      In2_o  <= in2_nxt;
      Busy_o <= busy_nxt;
    end
  end

endmodule

// File: tb/tb_hbridge_dir_ctrl.sv
// tb/tb_hbridge_dir_ctrl.sv - self-checking bench for hbridge_dir_ctrl
module tb_hbridge_dir_ctrl;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  logic pwm   = 1'b0;
  logic dir   = 1'b0;
  logic en    = 1'b0;
  logic in1;
  logic in2;
  logic dir_o;
  logic busy;

  int   total  = 0;
  int   passed = 0;
  int   phase  = 0;
  logic last_pwm = 1'b0;
  logic pwm_q[$];

  always #5 clk = ~clk;

  hbridge_dir_ctrl #(
    .DEAD_CYCLES(8),
    .DIR_STABLE_CYCLES(4)
  ) dut (
    .Clk_i  (clk),
    .Reset_i(rst_n),
    .Pwm_i  (pwm),
    .Dir_i  (dir),
    .En_i   (en),
    .In1_o  (in1),
    .In2_o  (in2),
    .Dir_o  (dir_o),
    .Busy_o (busy)
  );

  initial begin
    #200000;
    $display("FAIL watchdog: time %0t exceeded limit 200000", $time);
    $fatal(1);
  end

  // one clock: pop the PWM value the DUT just sampled, check safety, drive next 50% PWM bit
  task automatic tick();
    @(posedge clk);
    #1;
    last_pwm = pwm_q.pop_front();
    total++;
    if ((in1 & in2) !== 1'b0) $display("FAIL safety: in1=%b in2=%b required not both high at %0t", in1, in2, $time);
    else passed++;
    phase = (phase + 1) % 4;
    pwm   = (phase < 2);
    pwm_q.push_back(pwm);
  endtask

  task automatic run_dead(output int lat, output int len, output bit low_ok);
    lat = -1;
    len = 0;
    low_ok = 1'b1;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (busy === 1'b1) begin
        lat = i;
        break;
      end
    end
    if (lat < 0) return;
    len = 1;
    if (in1 !== 1'b0 || in2 !== 1'b0) low_ok = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b1) break;
      len++;
      if (in1 !== 1'b0 || in2 !== 1'b0) low_ok = 1'b0;
    end
  endtask

  task automatic test_reset();
    int lat, len, highs, err;
    bit ok;
    rst_n = 1'b0; en = 1'b1; dir = 1'b0;
    repeat (3) tick();
    total++; if ({in1, in2, dir_o, busy} !== 4'b0000) $display("FAIL reset_outs: got %b required 0000", {in1, in2, dir_o, busy}); else passed++;
    rst_n = 1'b1;
    run_dead(lat, len, ok);
    total++; if (lat !== 1) $display("FAIL en_busy_latency: got %0d required 1", lat); else passed++;
    total++; if (len !== 8) $display("FAIL en_dead_len: got %0d required 8", len); else passed++;
    total++; if (ok !== 1'b1) $display("FAIL en_dead_low: outputs not low during dead-time"); else passed++;
    total++; if ({in1, in2, dir_o, busy} !== {last_pwm, 3'b000}) $display("FAIL first_drive: got %b required %b", {in1, in2, dir_o, busy}, {last_pwm, 3'b000}); else passed++;
    highs = 0; err = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (in1 === 1'b1) highs++;
      if (in1 !== last_pwm || in2 !== 1'b0 || busy !== 1'b0) err++;
    end
    total++; if (highs !== 8) $display("FAIL fwd_duty: got %0d/16 high required 8/16", highs); else passed++;
    total++; if (err !== 0) $display("FAIL fwd_tracking: got %0d errors required 0", err); else passed++;
  endtask

  task automatic test_glitch();
    int busy_seen, err;
    dir = 1'b1;
    repeat (3) tick();
    dir = 1'b0;
    busy_seen = 0; err = 0;
    for (int i = 0; i < 24; i++) begin
      tick();
      if (busy !== 1'b0) busy_seen++;
      if (in1 !== last_pwm || in2 !== 1'b0 || dir_o !== 1'b0) err++;
    end
    total++; if (busy_seen !== 0) $display("FAIL glitch_busy: got %0d busy clocks required 0", busy_seen); else passed++;
    total++; if (err !== 0) $display("FAIL glitch_tracking: got %0d errors required 0", err); else passed++;
  endtask

  task automatic test_toggle_in_dead();
    int lat, len, busy_seen, err;
    bit ok;
    dir = 1'b1;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (busy === 1'b1) begin
        lat = i;
        break;
      end
    end
    total++; if (lat !== 7) $display("FAIL toggle_latency: got %0d required 7", lat); else passed++;
    dir = 1'b0;
    len = 1; ok = 1'b1;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (busy !== 1'b1) break;
      len++;
      if (in1 !== 1'b0 || in2 !== 1'b0) ok = 1'b0;
    end
    total++; if (len !== 8) $display("FAIL toggle_dead_len: got %0d required 8", len); else passed++;
    total++; if (ok !== 1'b1) $display("FAIL toggle_dead_low: outputs not low during dead-time"); else passed++;
    total++; if ({in1, in2, dir_o} !== {last_pwm, 2'b00}) $display("FAIL toggle_resume: got %b required %b", {in1, in2, dir_o}, {last_pwm, 2'b00}); else passed++;
    busy_seen = 0; err = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (busy !== 1'b0) busy_seen++;
      if (in1 !== last_pwm || in2 !== 1'b0) err++;
    end
    total++; if (busy_seen + err !== 0) $display("FAIL toggle_settle: got %0d busy %0d track errors required 0", busy_seen, err); else passed++;
  endtask

  task automatic test_disable_mid_dead();
    int lat, len;
    bit ok;
    en = 1'b0;
    tick();
    total++; if ({in1, in2, busy} !== 3'b000) $display("FAIL disable_fwd: got %b required 000", {in1, in2, busy}); else passed++;
    en = 1'b1;
    tick();
    total++; if (busy !== 1'b1) $display("FAIL reenable_busy: got %b required 1", busy); else passed++;
    repeat (2) tick();
    total++; if (busy !== 1'b1) $display("FAIL dead_clock3_busy: got %b required 1", busy); else passed++;
    en = 1'b0;
    tick();
    total++; if ({in1, in2, busy} !== 3'b000) $display("FAIL disable_dead: got %b required 000", {in1, in2, busy}); else passed++;
    en = 1'b1;
    run_dead(lat, len, ok);
    total++; if (lat !== 1 || len !== 8 || ok !== 1'b1) $display("FAIL restart_dead: got lat=%0d len=%0d low=%0d required 1 8 1", lat, len, ok); else passed++;
    total++; if ({in1, in2} !== {last_pwm, 1'b0}) $display("FAIL restart_drive: got %b required %b", {in1, in2}, {last_pwm, 1'b0}); else passed++;
  endtask

  task automatic test_reversal();
    int lat, len, highs, err;
    bit ok;
    dir = 1'b1;
    run_dead(lat, len, ok);
    total++; if (lat !== 7) $display("FAIL rev_latency: got %0d required 7", lat); else passed++;
    total++; if (len !== 8) $display("FAIL rev_dead_len: got %0d required 8", len); else passed++;
    total++; if (ok !== 1'b1) $display("FAIL rev_dead_low: outputs not low during dead-time"); else passed++;
    total++; if ({in1, in2, dir_o} !== {1'b0, last_pwm, 1'b1}) $display("FAIL rev_first: got %b required %b", {in1, in2, dir_o}, {1'b0, last_pwm, 1'b1}); else passed++;
    highs = 0; err = 0;
    for (int i = 0; i < 16; i++) begin
      tick();
      if (in2 === 1'b1) highs++;
      if (in2 !== last_pwm || in1 !== 1'b0 || dir_o !== 1'b1) err++;
    end
    total++; if (highs !== 8) $display("FAIL rev_duty: got %0d/16 high required 8/16", highs); else passed++;
    total++; if (err !== 0) $display("FAIL rev_tracking: got %0d errors required 0", err); else passed++;
  endtask

  task automatic test_async_reset();
    bit found;
    time t0;
    found = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (in2 === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    total++; if (found !== 1'b1) $display("FAIL async_setup: in2 never high, got %b", in2); else passed++;
    t0 = $time;
    rst_n = 1'b0;
    #1;
    total++; if ({in1, in2, dir_o, busy} !== 4'b0000 || ($time - t0) !== 1) $display("FAIL async_reset: got %b required 0000", {in1, in2, dir_o, busy}); else passed++;
    tick();
    rst_n = 1'b1;
    en = 1'b0;
    tick();
  endtask

  initial begin
    pwm_q.push_back(pwm);
    test_reset();
    test_glitch();
    test_toggle_in_dead();
    test_disable_mid_dead();
    test_reversal();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/hbridge_dir_ctrl.md
# hbridge_dir_ctrl

Direction and dead-time controller for the MG33 DC motor H-bridge. It sits directly downstream of `pwm_top`, taking `Pwm_o` plus a direction switch and an enable, and drives the two H-bridge inputs. It guarantees that both legs are off for a programmable dead-time on every direction change and every enable. It also guarantees that both bridge inputs are never high at the same time.

## Interface
- `DEAD_CYCLES`, default 8: clocks both outputs are held low between drive phases; legal range 1..255.
- `DIR_STABLE_CYCLES`, default 4: consecutive clocks the synchronized `Dir_i` must differ from the accepted direction before the change is accepted; legal range 1..255.
- `Clk_i`  in  1  system clock, same domain as `pwm_top`.
- `Reset_i`  in  1  asynchronous, active-low reset.
- `Pwm_i`  in  1  PWM from `pwm_top` `Pwm_o`; synchronous to `Clk_i`.
- `Dir_i`  in  1  direction switch, asynchronous: 0 = forward, 1 = reverse.
- `En_i`  in  1  motor enable; synchronous, level-sensitive.
- `In1_o`  out  1  H-bridge input 1, forward leg; registered.
- `In2_o`  out  1  H-bridge input 2, reverse leg; registered.
- `Dir_o`  out  1  direction currently applied or about to be applied; registered.
- `Busy_o`  out  1  high during the dead-time window; registered.

## Operation
- **Reset values:** `In1_o`=0, `In2_o`=0, `Dir_o`=0, `Busy_o`=0. State = OFF, dead counter = 0, accepted direction `dir_req`=0, both synchronizer flops = 0, filter counter = 0.
- **Direction input path:** `Dir_i` passes through a 2-flop synchronizer, producing `dir_s`.
- **Direction filter:**
  - Filter counter increments while `dir_s` != `dir_req`.
  - Counter clears to 0 whenever `dir_s` == `dir_req`.
  - When the counter reaches `DIR_STABLE_CYCLES`, `dir_req` <= `dir_s` and the counter clears.
  - Counter width is 8 bits; it never wraps because it clears at the threshold.
- **FSM states:** OFF, DEAD, FWD, REV.
  - OFF: outputs low, `Busy_o`=0. If `En_i`=1, go to DEAD and load the counter with `DEAD_CYCLES`.
  - DEAD: outputs low, `Busy_o`=1, counter decrements each clock.
    - `En_i`=0 in DEAD: go to OFF immediately; the count is abandoned.
    - Counter == 1 with `En_i`=1: latch `Dir_o` <= `dir_req`, then go to FWD if `dir_req`=0, else REV.
  - FWD: `In1_o` = `Pwm_i`, `In2_o`=0.
    - `En_i`=0: go to OFF.
    - Else if `dir_req` != `Dir_o`: go to DEAD and load the counter.
  - REV: mirror of FWD, with `In2_o` = `Pwm_i` and `In1_o`=0.
- **Priority:** `En_i`=0 beats a direction change in every state.
- **Dead-time is never skipped:** OFF always passes through DEAD before driving, so any two drive phases are separated by at least `DEAD_CYCLES` both-low clocks.
- **Direction toggling during DEAD:** the dead-time completes in full. The exit direction is `dir_req` as sampled on the final DEAD clock, which may equal the previous direction.
- **Output registers:** outputs are decoded from the next state and registered, so outputs change on the same edge the state changes.
- **Safety invariant:** `In1_o` & `In2_o` == 0 at all times, including during reset assertion and release.
- **Reset mid-operation:** asserting `Reset_i` forces outputs to 0 asynchronously, without waiting for a clock edge.

## Timing
- **Pwm_i to In1_o/In2_o in a drive state:** 1-clock latency. The output at edge k+1 equals `Pwm_i` sampled at edge k. No duty-cycle distortion.
- **Dir_i edge to accepted direction:** `dir_req` updates 2 + `DIR_STABLE_CYCLES` clocks after `Dir_i` changes, provided `Dir_i` stays stable.
  - Outputs go low and `Busy_o` rises 1 clock after `dir_req` updates.
- **DEAD window length:** `Busy_o` is high for exactly `DEAD_CYCLES` clocks. The first drive-output clock immediately follows the last `Busy_o`=1 clock.
- **Enable rise:** `En_i` rise in OFF produces `Busy_o`=1 at the next edge. Drive begins `DEAD_CYCLES` + 1 edges after the `En_i` sample.
- **Enable fall:** `En_i` fall produces outputs = 0 and `Busy_o` = 0 at the next edge.
- **Glitch rejection:** a `Dir_i` glitch shorter than `DIR_STABLE_CYCLES` synchronized clocks causes no state change.

## Test plan
All scenarios use `DEAD_CYCLES`=8 and `DIR_STABLE_CYCLES`=4, with `Pwm_i` driven by `pwm_top` at `Sel_i`=2 (50%).
- **Reset and enable:** release reset with `En_i`=1, `Dir_i`=0. Required response: `Busy_o` high for exactly 8 clocks, then `In1_o` follows `Pwm_i` delayed 1 clock, `In2_o` stays 0, and the measured duty is 50%.
- **Direction reversal:** toggle `Dir_i` 0→1 while in FWD. Required response: `dir_req` flips after 6 clocks, then outputs go low with `Busy_o`=1 for 8 clocks. After that `In2_o` follows `Pwm_i`, `In1_o` stays 0, and `Dir_o`=1.
- **Glitch rejection:** apply a `Dir_i` pulse of 3 clocks while in FWD. Required response: no DEAD entry, `In1_o` keeps tracking `Pwm_i`, and `Dir_o` stays 0.
- **Disable mid-dead-time:** deassert `En_i` on the 3rd DEAD clock. Required response: next edge state is OFF with all outputs 0. Re-asserting `En_i` restarts a full 8-clock DEAD.
- **Dir_i toggled back during DEAD:** toggle `Dir_i` 0→1, then back 1→0 during DEAD. Required response: the full 8-clock window still completes, then the block resumes FWD with `Dir_o`=0.
- **Safety checks, all scenarios:** assert `In1_o` & `In2_o` never both 1. Assert that an async `Reset_i` pulse mid-FWD clears all outputs with no clock edge.
